division2: RTL and testbench
============================

DIVISION2 -- requirements
Module: division2

Interface
REQ-001 One clock; reset is synchronous and active-high.
REQ-002 Ports, in order:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- a_operand  input  32  IEEE-754 binary32 dividend
- b_operand  input  32  IEEE-754 binary32 divisor
- result  output  32  binary32 quotient, registered
- Exception  output  1  invalid/overflow flag, registered
- zero_division  output  1  divisor-is-zero flag, registered
REQ-003 Parameters: none.

Function
REQ-004 Free-running operation, no handshake. Operands are sampled every cycle; outputs update on the next rising clk edge (latency 1 cycle, throughput 1 per cycle).
REQ-005 Field split: sign bit 31, exponent bits 30:23 with bias 127, fraction bits 22:0.
REQ-006 Result sign is the XOR of the operand signs, for every case including zero and Inf results.
REQ-007 Subnormals are flushed to zero: an operand with exponent 0 is treated as signed zero.
REQ-008 zero_division=1 iff b exponent==0, i.e. the divisor is ±0 or subnormal.
REQ-009 Special cases are resolved in priority order:
- a or b is NaN -> 0x7FC00000, Exception=1
- 0/0 or Inf/Inf -> 0x7FC00000, Exception=1
- Inf/finite -> signed Inf, Exception=1
- finite/Inf -> signed 0, Exception=1
- nonzero/0 -> signed Inf (0x7F800000 | sign), Exception=0
- 0/nonzero -> signed 0, Exception=0
REQ-010 Normal path, mantissa: quotient q = ({1,ma} << 25) / {1,mb}, 26 bits, computed by a combinational unrolled restoring divider; the remainder is kept for the sticky bit.
REQ-011 Normal path, normalisation: if q[25]=1 the exponent is ea-eb+127; otherwise q is shifted left 1 and the exponent is ea-eb+126. Exponent arithmetic is 10-bit signed.
REQ-012 Normal path, rounding: round-to-nearest-even using guard bit plus sticky (remaining q bit OR remainder!=0). A mantissa carry-out increments the exponent.
REQ-013 Overflow: final exponent >= 255 -> signed Inf, Exception=1.
REQ-014 Underflow: final exponent <= 0 -> signed zero (flush), Exception=0.
REQ-015 Exception=0 for all normal in-range results.

Reset
REQ-016 While rst=1 at a rising edge: result=0x00000000, Exception=0, zero_division=0.
REQ-017 Reset has priority over operand sampling. The first valid output appears one edge after rst deasserts.
REQ-018 Asserting reset mid-stream discards the in-flight result; there is no other state.

Structure
REQ-019 Package division2_pkg holds:
- EXP_BIAS=127
- QNAN=32'h7FC00000
- POS_INF=32'h7F800000
- field width constants
REQ-020 Sub-module fp_mant_div implements the combinational 26-bit quotient and remainder.
REQ-021 The top level holds the classification, exponent, normalisation, rounding, special-case muxing and output registers. Target size is about 150-300 lines total.

Verification
REQ-022 0x41200000 / 0x40000000 (10/2) -> 0x40A00000, Exception=0, zero_division=0.
REQ-023 0x40F00000 / 0x40400000 (7.5/3) -> 0x40200000; 0xC1000000 / 0x40000000 -> 0xC0800000.
REQ-024 0x3F800000 / 0x00000000 -> 0x7F800000, Exception=0, zero_division=1; 0x00000000 / 0x00000000 -> 0x7FC00000, Exception=1, zero_division=1.
REQ-025 0x7FC00001 / 0x40400000 -> 0x7FC00000, Exception=1.
REQ-026 0x00800000 / 0x7F7FFFFF -> 0x00000000 (underflow flush), Exception=0; 0x7F7FFFFF / 0x00800000 -> 0x7F800000, Exception=1.
REQ-027 Check latency: a new operand pair is applied each cycle and the matching result appears exactly 1 edge later. Assert rst mid-stream and check all outputs are 0 on the next edge.

Source files
------------

// File: rtl/division2_pkg.sv
// division2_pkg -- shared definitions for the binary32 divider.
// Holds the field layout of an IEEE-754 single, the constant encodings
// used by the special-case mux, and a small operand classifier.
package division2_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = FRAC_W + 1;   // with hidden one
    localparam int QUO_W    = 26;           // quotient bits out of the divider
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        FP_ZERO,   // true zero or subnormal (flushed)
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_cls_t;

    function automatic fp_cls_t fp_classify(input fp32_t x);
        if (x.exp == '0)
            return FP_ZERO;
        else if (x.exp == '1)
            return (x.frac == '0) ? FP_INF : FP_NAN;
        else
            return FP_NORM;
    endfunction

endpackage

// File: rtl/fp_mant_div.sv
// fp_mant_div -- combinational unrolled restoring divider for the mantissas.
// Computes quo = ({1,ma} << 25) / {1,mb} and the final remainder.
// Ports:
//   ma_i  [22:0] dividend fraction (hidden one added here)
//   mb_i  [22:0] divisor fraction  (hidden one added here)
//   quo_o [25:0] quotient
//   rem_o [23:0] remainder, nonzero means the quotient is inexact
module fp_mant_div
    import division2_pkg::*;
(
    input  logic [FRAC_W-1:0] ma_i,
    input  logic [FRAC_W-1:0] mb_i,
    output logic [QUO_W-1:0]  quo_o,
    output logic [MANT_W-1:0] rem_o
);

    logic [MANT_W-1:0] dvs;
    logic [MANT_W:0]   r;
    logic [QUO_W-1:0]  quo;

    assign dvs = {1'b1, mb_i};

    // Partial remainder always stays below 2*divisor, so one extra bit
    // over the mantissa width is enough to hold it before each compare.
    always_comb begin
        r   = {1'b0, 1'b1, ma_i};
        quo = '0;
        for (int i = QUO_W - 1; i >= 0; i--) begin
            if (r >= {1'b0, dvs}) begin
                quo[i] = 1'b1;
                r      = r - {1'b0, dvs};
            end
            if (i > 0)
                r = r << 1;
        end
    end

    assign quo_o = quo;
    assign rem_o = r[MANT_W-1:0];

endmodule

// File: rtl/division2.sv
// division2 -- single-cycle IEEE-754 binary32 divider, registered outputs.
// Subnormals are flushed to zero, rounding is round-to-nearest-even.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   a_operand      [31:0] dividend
//   b_operand      [31:0] divisor
//   result         [31:0] quotient (1-cycle latency)
//   Exception      invalid / overflow flag
//   zero_division  divisor exponent is zero (zero or subnormal)
module division2
    import division2_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic [31:0] result,
    output logic        Exception,
    output logic        zero_division
);

    fp32_t   a_f, b_f;
    fp_cls_t a_cls, b_cls;
    logic    sign;

    assign a_f   = a_operand;
    assign b_f   = b_operand;
    assign a_cls = fp_classify(a_f);
    assign b_cls = fp_classify(b_f);
    assign sign  = a_f.sign ^ b_f.sign;

    // ---------------- mantissa divide ----------------
    logic [QUO_W-1:0]  quo;
    logic [MANT_W-1:0] rem;

    fp_mant_div u_mdiv (
        .ma_i  (a_f.frac),
        .mb_i  (b_f.frac),
        .quo_o (quo),
        .rem_o (rem)
    );

    // ---------------- normalise ----------------
    // Mantissa ratio lies in (0.5, 2): the leading one is at bit 25 or 24.
    logic              q_hi;
    logic [FRAC_W-1:0] mant;
    logic              guard, sticky;
    logic signed [9:0] exp_pre, exp_fin;

    assign q_hi = quo[QUO_W-1];

    always_comb begin
        if (q_hi) begin
            mant   = quo[24:2];
            guard  = quo[1];
            sticky = quo[0] | (|rem);
        end else begin
            mant   = quo[23:1];
            guard  = quo[0];
            sticky = |rem;
        end
    end

    assign exp_pre = 10'(a_f.exp) - 10'(b_f.exp)
                   + (q_hi ? 10'(EXP_BIAS) : 10'(EXP_BIAS - 1));

    // ---------------- round to nearest even ----------------
    logic              rnd_up;
    logic [FRAC_W:0]   mant_rnd;
    logic              carry;

    assign rnd_up   = guard & (sticky | mant[0]);
    assign mant_rnd = {1'b0, mant} + {{FRAC_W{1'b0}}, rnd_up};
    // On carry-out the fraction wraps to zero, which is the correct
    // fraction for the next binade.
    assign carry    = mant_rnd[FRAC_W];
    assign exp_fin  = exp_pre + {9'd0, carry};

    // ---------------- special-case mux ----------------
    logic [31:0] res_d, res_q;
    logic        exc_d, exc_q;
    logic        zdiv_d, zdiv_q;
    logic [31:0] s_inf, s_zero;

    assign s_inf  = POS_INF | {sign, 31'd0};
    assign s_zero = {sign, 31'd0};

    always_comb begin
        res_d  = '0;
        exc_d  = 1'b0;
        zdiv_d = (b_cls == FP_ZERO);
        if (a_cls == FP_NAN || b_cls == FP_NAN) begin
            res_d = QNAN;
            exc_d = 1'b1;
        end else if ((a_cls == FP_ZERO && b_cls == FP_ZERO) ||
                     (a_cls == FP_INF  && b_cls == FP_INF)) begin
            res_d = QNAN;
            exc_d = 1'b1;
        end else if (a_cls == FP_INF) begin
            res_d = s_inf;
            exc_d = 1'b1;
        end else if (b_cls == FP_INF) begin
            res_d = s_zero;
            exc_d = 1'b1;
        end else if (b_cls == FP_ZERO) begin
            res_d = s_inf;
        end else if (a_cls == FP_ZERO) begin
            res_d = s_zero;
        end else if (exp_fin >= 10'sd255) begin
            res_d = s_inf;
            exc_d = 1'b1;
        end else if (exp_fin <= 10'sd0) begin
            res_d = s_zero;
        end else begin
            res_d = {sign, exp_fin[EXP_W-1:0], mant_rnd[FRAC_W-1:0]};
        end
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q  <= '0;
            exc_q  <= 1'b0;
            zdiv_q <= 1'b0;
        end else begin
            res_q  <= res_d;
            exc_q  <= exc_d;
            zdiv_q <= zdiv_d;
        end
    end

    assign result        = res_q;
    assign Exception     = exc_q;
    assign zero_division = zdiv_q;

endmodule

// File: tb/tb_division2.sv
// tb_division2 -- scoreboard bench for division2.
// Each cycle a new operand pair is driven and its expected output pushed;
// one edge later the output is popped and compared.
module tb_division2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_op, b_op;
    logic [31:0] result;
    logic        Exception, zero_division;

    division2 dut (
        .clk           (clk),
        .rst           (rst),
        .a_operand     (a_op),
        .b_operand     (b_op),
        .result        (result),
        .Exception     (Exception),
        .zero_division (zero_division)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic        zd;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: special cases from the case table, normal path via
    // double-precision division then RNE rounding to 24 bits.
    function automatic logic [63:0] to_dbl(input logic [7:0] e, input logic [22:0] f);
        logic [10:0] de;
        de = 11'(e) + 11'd896;
        return {1'b0, de, f, 29'd0};
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        x;
        logic        s, za, zb, ia, ib, na, nb;
        real         q;
        logic [63:0] qb;
        logic [24:0] m;
        int          e;
        s  = a[31] ^ b[31];
        za = (a[30:23] == 8'h00);
        zb = (b[30:23] == 8'h00);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        x.zd  = zb;
        x.tag = "";
        x.exc = 1'b0;
        if (na || nb)                      begin x.res = 32'h7FC00000; x.exc = 1'b1; end
        else if ((za && zb) || (ia && ib)) begin x.res = 32'h7FC00000; x.exc = 1'b1; end
        else if (ia)                       begin x.res = {s, 31'h7F800000}; x.exc = 1'b1; end
        else if (ib)                       begin x.res = {s, 31'd0}; x.exc = 1'b1; end
        else if (zb)                       x.res = {s, 31'h7F800000};
        else if (za)                       x.res = {s, 31'd0};
        else begin
            q  = $bitstoreal(to_dbl(a[30:23], a[22:0])) / $bitstoreal(to_dbl(b[30:23], b[22:0]));
            qb = $realtobits(q);
            e  = int'(qb[62:52]) - 896;
            m  = {2'b01, qb[51:29]};
            if (qb[28] && ((|qb[27:0]) || m[0]))
                m = m + 25'd1;
            if (m[24]) e++;
            if (e >= 255)    begin x.res = {s, 31'h7F800000}; x.exc = 1'b1; end
            else if (e <= 0) x.res = {s, 31'd0};
            else             x.res = {s, e[7:0], m[22:0]};
        end
        return x;
    endfunction

    // Drive one cycle of stimulus with its expectation, then check it one
    // edge later.
    task automatic cyc(input logic r, input logic [31:0] av, input logic [31:0] bv,
                       input exp_t e);
        exp_t got;
        rst  = r;
        a_op = av;
        b_op = bv;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_empty got=0 exp=1");
        end else begin
            got = sb.pop_front();
            chk({got.tag, ".res"}, result, got.res);
            chk({got.tag, ".exc"}, {31'd0, Exception}, {31'd0, got.exc});
            chk({got.tag, ".zd"},  {31'd0, zero_division}, {31'd0, got.zd});
        end
    endtask

    task automatic cyc_m(input string tag, input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        e     = model(av, bv);
        e.tag = tag;
        cyc(1'b0, av, bv, e);
    endtask

    task automatic cyc_k(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] res, input logic exc, input logic zd);
        exp_t e;
        e.res = res; e.exc = exc; e.zd = zd; e.tag = tag;
        cyc(1'b0, av, bv, e);
    endtask

    task automatic cyc_rst(input string tag, input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        e.res = 32'd0; e.exc = 1'b0; e.zd = 1'b0; e.tag = tag;
        cyc(1'b1, av, bv, e);
    endtask

    function automatic logic [31:0] mk(input logic s, input int e);
        logic [7:0] ee;
        ee = 8'(e);
        return {s, ee, 23'($urandom)};
    endfunction

    typedef struct {
        logic [31:0] a, b, res;
        logic        exc, zd;
    } dvec_t;

    dvec_t dv[$] = '{
        '{32'h41200000, 32'h40000000, 32'h40A00000, 1'b0, 1'b0},
        '{32'h40F00000, 32'h40400000, 32'h40200000, 1'b0, 1'b0},
        '{32'hC1000000, 32'h40000000, 32'hC0800000, 1'b0, 1'b0},
        '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b1},
        '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b1},
        '{32'h7FC00001, 32'h40400000, 32'h7FC00000, 1'b1, 1'b0},
        '{32'h00800000, 32'h7F7FFFFF, 32'h00000000, 1'b0, 1'b0},
        '{32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 1'b1, 1'b0},
        '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b0},
        '{32'hFF800000, 32'h40400000, 32'hFF800000, 1'b1, 1'b0},
        '{32'h3F800000, 32'hFF800000, 32'h80000000, 1'b1, 1'b0},
        '{32'h80000000, 32'h40400000, 32'h80000000, 1'b0, 1'b0},
        '{32'h3F800000, 32'h80000000, 32'hFF800000, 1'b0, 1'b1},
        '{32'h3F800000, 32'h00400000, 32'h7F800000, 1'b0, 1'b1},
        '{32'h00400000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0},
        '{32'h40400000, 32'h7FC00000, 32'h7FC00000, 1'b1, 1'b0},
        '{32'h7F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b1},
        '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0},
        '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0}
    };

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        a_op = '0;
        b_op = '0;
        // reset state, even with live operands on the inputs
        cyc_rst("rst0", 32'h00000000, 32'h00000000);
        cyc_rst("rst1", 32'h41200000, 32'h40000000);

        // directed table, back to back (one result per edge)
        foreach (dv[i])
            cyc_k($sformatf("dir%0d", i), dv[i].a, dv[i].b, dv[i].res, dv[i].exc, dv[i].zd);

        // mid-stream reset discards the in-flight pair
        cyc_m("pre_rst", 32'h40F00000, 32'h40400000);
        cyc_rst("mid_rst0", 32'h7F7FFFFF, 32'h00800000);
        cyc_rst("mid_rst1", 32'h00000000, 32'h00000000);
        cyc_k("post_rst", 32'h41200000, 32'h40000000, 32'h40A00000, 1'b0, 1'b0);

        // random normals in a comfortable exponent range
        for (int i = 0; i < 300; i++)
            cyc_m($sformatf("rnd%0d", i),
                  mk(1'($urandom), int'($urandom_range(100, 154))),
                  mk(1'($urandom), int'($urandom_range(100, 154))));

        // random around the overflow and underflow edges
        for (int i = 0; i < 100; i++)
            cyc_m($sformatf("ovf%0d", i),
                  mk(1'($urandom), int'($urandom_range(252, 254))),
                  mk(1'($urandom), int'($urandom_range(124, 127))));
        for (int i = 0; i < 100; i++)
            cyc_m($sformatf("unf%0d", i),
                  mk(1'($urandom), int'($urandom_range(1, 3))),
                  mk(1'($urandom), int'($urandom_range(127, 130))));

        // random mix including specials and subnormals
        for (int i = 0; i < 100; i++) begin
            logic [31:0] av, bv;
            av = $urandom;
            bv = $urandom;
            case ($urandom_range(0, 3))
                0: av[30:23] = 8'h00;
                1: bv[30:23] = 8'h00;
                2: av[30:23] = 8'hFF;
                default: bv[30:23] = 8'hFF;
            endcase
            if ($urandom_range(0, 1) == 1) av[22:0] = '0;
            if ($urandom_range(0, 1) == 1) bv[22:0] = '0;
            cyc_m($sformatf("spc%0d", i), av, bv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
